// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// Instruction-fetch controller. Translates the current PC into an
// instruction-memory word index, performs a req/ack read, and presents the
// fetched word to decode under a valid/ready handshake. Each accepted
// instruction produces a one-cycle pc_step pulse back to the PC register.
//
// Ports:
//   if_clock   - clock, rising edge
//   rst        - asynchronous reset, active low
//   if_ena     - fetch enable (gates only the start of a new request)
//   pc_addr    - current PC value
//   flush      - redirect; discards pending/held instruction, clears fault
//   pc_step    - one-cycle pulse: PC register loads its next address
//   mem_req    - instruction-memory read request
//   mem_addr   - word index of the request
//   mem_ack    - memory response strobe (mem_rdata valid same cycle)
//   mem_rdata  - instruction word from memory
//   inst_valid - inst_out/inst_pc hold a valid instruction
//   inst_ready - decode accepts the instruction
//   inst_out   - fetched instruction
//   inst_pc    - PC of inst_out
//   addr_err   - sticky fetch-address fault
module if_fetch_unit #(
  parameter logic [31:0] PC_START = 32'h0040_0000,
  parameter int unsigned ADDR_W   = 11
) (
  input  logic              if_clock,
  input  logic              rst,
  input  logic              if_ena,
  input  logic [31:0]       pc_addr,
  input  logic              flush,
  output logic              pc_step,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_out,
  output logic [31:0]       inst_pc,
  output logic              addr_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN,
    S_ERR
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_inst_out;
  logic [31:0]         r_inst_pc;

  logic [31:0]         w_offset;
  logic                w_fault;
  logic [ADDR_W-1:0]   w_index;
  logic                w_load_req;
  logic                w_capture;

  // Address translation relative to the memory base.
  assign w_offset = pc_addr - PC_START;
  assign w_fault  = (pc_addr[1:0] != 2'b00)
                 || (w_offset[1:0] != 2'b00)
                 || (pc_addr < PC_START)
                 || (w_offset[31:ADDR_W+2] != '0);
  assign w_index  = w_offset[ADDR_W+1:2];

  always_comb begin
    w_next     = r_state;
    w_load_req = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (if_ena && !flush) begin
          if (w_fault) begin
            w_next = S_ERR;
          end else begin
            w_load_req = 1'b1;
            w_next     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (flush) begin
            w_next = S_IDLE;
          end else begin
            w_capture = 1'b1;
            w_next    = S_HOLD;
          end
        end else if (flush) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_ack) w_next = S_IDLE;
      end
      S_HOLD: begin
        // flush wins over inst_ready so a redirected instruction never steps the PC.
        if (flush || inst_ready) w_next = S_IDLE;
      end
      S_ERR: begin
        if (flush) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge if_clock or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge if_clock or negedge rst) begin
    if (!rst) begin
      r_mem_addr <= '0;
      r_inst_pc  <= '0;
      r_inst_out <= '0;
    end else begin
      if (w_load_req) begin
        r_mem_addr <= w_index;
        r_inst_pc  <= pc_addr;
      end
      if (w_capture) begin
        r_inst_out <= mem_rdata;
      end
    end
  end

  assign mem_req    = (r_state == S_REQ) || (r_state == S_DRAIN);
  assign inst_valid = (r_state == S_HOLD);
  assign addr_err   = (r_state == S_ERR);
  assign pc_step    = (r_state == S_HOLD) && inst_ready && !flush;
  assign mem_addr   = r_mem_addr;
  assign inst_out   = r_inst_out;
  assign inst_pc    = r_inst_pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        if_clock;
  logic        rst;
  logic        if_ena;
  logic [31:0] pc_addr;
  logic        flush;
  logic        pc_step;
  logic        mem_req;
  logic [10:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  if_fetch_unit #(.PC_START(32'h0040_0000), .ADDR_W(11)) dut (
    .if_clock   (if_clock),
    .rst        (rst),
    .if_ena     (if_ena),
    .pc_addr    (pc_addr),
    .flush      (flush),
    .pc_step    (pc_step),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .addr_err   (addr_err)
  );

  initial if_clock = 1'b0;
  always #5 if_clock = ~if_clock;

  task automatic tick;
    @(posedge if_clock);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; if_ena = 1'b0; pc_addr = '0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; inst_ready = 1'b0;
    #3;
    checks++; if ({pc_step, mem_req, inst_valid, addr_err} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {pc_step, mem_req, inst_valid, addr_err}); end
    checks++; if (mem_addr !== 11'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 000", mem_addr); end
    checks++; if (inst_out !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0/0", inst_out, inst_pc); end
    tick;
    rst = 1'b1;
    tick;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b expected 0", mem_req); end
  endtask

  // Minimum-latency fetch, then a back-to-back second request at cycle 4.
  task automatic test_basic;
    int steps = 0;
    pc_addr = 32'h0040_0000; if_ena = 1'b1; inst_ready = 1'b1; mem_rdata = 32'h2008_0005;
    #1;
    steps += int'(pc_step);
    tick; // cycle 1: REQ
    checks++; if (mem_req !== 1'b1 || mem_addr !== 11'h000) begin errors++; $display("FAIL basic_req: got req=%b addr=%h expected 1/000", mem_req, mem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", inst_valid); end
    steps += int'(pc_step);
    mem_ack = 1'b1;
    tick; // cycle 2: HOLD
    mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_out !== 32'h2008_0005 || inst_pc !== 32'h0040_0000) begin errors++; $display("FAIL basic_hold: got v=%b out=%h pc=%h expected 1/20080005/00400000", inst_valid, inst_out, inst_pc); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop: got %b expected 0", mem_req); end
    steps += int'(pc_step);
    tick; // cycle 3: IDLE
    checks++; if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL basic_idle: got v=%b req=%b expected 0/0", inst_valid, mem_req); end
    steps += int'(pc_step);
    checks++; if (steps !== 1) begin errors++; $display("FAIL basic_pc_step_count: got %0d expected 1", steps); end
    tick; // cycle 4: next REQ
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL basic_next_req: got %b expected 1", mem_req); end
    if_ena = 1'b0; mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    checks++; if (inst_out !== 32'hDEAD_BEEF || pc_step !== 1'b1) begin errors++; $display("FAIL basic_second: got out=%h step=%b expected deadbeef/1", inst_out, pc_step); end
    tick;
    inst_ready = 1'b0;
  endtask

  task automatic test_slow_ack;
    pc_addr = 32'h0040_0010; if_ena = 1'b1; inst_ready = 1'b0; mem_rdata = 32'hAABB_CCDD;
    tick;
    if_ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (mem_req !== 1'b1 || mem_addr !== 11'h004) begin errors++; $display("FAIL slow_req[%0d]: got req=%b addr=%h expected 1/004", i, mem_req, mem_addr); end
      if (i == 4) mem_ack = 1'b1;
      tick;
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL slow_req_drop: got %b expected 0", mem_req); end
    for (int i = 0; i < 4; i++) begin
      inst_ready = (i == 3);
      #1;
      checks++; if (inst_valid !== 1'b1 || inst_out !== 32'hAABB_CCDD || inst_pc !== 32'h0040_0010) begin errors++; $display("FAIL slow_hold[%0d]: got v=%b out=%h pc=%h expected 1/aabbccdd/00400010", i, inst_valid, inst_out, inst_pc); end
      checks++; if (pc_step !== (i == 3)) begin errors++; $display("FAIL slow_step[%0d]: got %b expected %b", i, pc_step, (i == 3)); end
      tick;
    end
    inst_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0 || pc_step !== 1'b0) begin errors++; $display("FAIL slow_done: got v=%b step=%b expected 0/0", inst_valid, pc_step); end
  endtask

  task automatic test_flush_drain;
    pc_addr = 32'h0040_0020; if_ena = 1'b1; inst_ready = 1'b1; mem_rdata = 32'h1234_5678;
    tick; // REQ 1
    if_ena = 1'b0;
    tick; // REQ 2
    flush = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1 || pc_step !== 1'b0) begin errors++; $display("FAIL drain_flush_cycle: got req=%b step=%b expected 1/0", mem_req, pc_step); end
    tick; // DRAIN, flush here is ignored
    checks++; if (mem_req !== 1'b1 || mem_addr !== 11'h008 || inst_valid !== 1'b0) begin errors++; $display("FAIL drain_state: got req=%b addr=%h v=%b expected 1/008/0", mem_req, mem_addr, inst_valid); end
    tick; // still DRAIN
    flush = 1'b0; mem_ack = 1'b1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL drain_wait: got %b expected 1", mem_req); end
    tick; // IDLE, data dropped
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0 || inst_valid !== 1'b0 || pc_step !== 1'b0) begin errors++; $display("FAIL drain_done: got req=%b v=%b step=%b expected 0/0/0", mem_req, inst_valid, pc_step); end
    tick;
    checks++; if (inst_valid !== 1'b0 || mem_req !== 1'b0 || inst_out === 32'h1234_5678) begin errors++; $display("FAIL drain_idle: got v=%b req=%b out=%h expected 0/0/not 12345678", inst_valid, mem_req, inst_out); end
    inst_ready = 1'b0;
  endtask

  task automatic test_flush_hold;
    pc_addr = 32'h0040_0004; if_ena = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick;
    if_ena = 1'b0; mem_ack = 1'b1;
    tick; // HOLD
    mem_ack = 1'b0; inst_ready = 1'b1; flush = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b1 || pc_step !== 1'b0) begin errors++; $display("FAIL hold_flush_step: got v=%b step=%b expected 1/0", inst_valid, pc_step); end
    tick;
    flush = 1'b0; inst_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0 || pc_step !== 1'b0) begin errors++; $display("FAIL hold_flush_drop: got v=%b step=%b expected 0/0", inst_valid, pc_step); end
    // ack and flush together in REQ: data dropped, straight back to IDLE
    if_ena = 1'b1;
    tick;
    if_ena = 1'b0; mem_ack = 1'b1; flush = 1'b1;
    tick;
    mem_ack = 1'b0; flush = 1'b0;
    checks++; if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL req_ack_flush: got v=%b req=%b expected 0/0", inst_valid, mem_req); end
  endtask

  task automatic test_addr_err;
    logic [31:0] bad [3];
    bad[0] = 32'h0040_0002; bad[1] = 32'h003F_FFFC; bad[2] = 32'h0040_2000;
    for (int i = 0; i < 3; i++) begin
      pc_addr = bad[i]; if_ena = 1'b1;
      tick;
      checks++; if (addr_err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL err_enter[%0d]: got err=%b req=%b expected 1/0", i, addr_err, mem_req); end
      tick;
      checks++; if (addr_err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL err_sticky[%0d]: got err=%b req=%b expected 1/0", i, addr_err, mem_req); end
      flush = 1'b1;
      tick;
      flush = 1'b0; if_ena = 1'b0;
      checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_clear[%0d]: got %b expected 0", i, addr_err); end
    end
    // last valid word of the window
    pc_addr = 32'h0040_1FFC; if_ena = 1'b1;
    tick;
    if_ena = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 11'h7FF || addr_err !== 1'b0) begin errors++; $display("FAIL top_word: got req=%b addr=%h err=%b expected 1/7ff/0", mem_req, mem_addr, addr_err); end
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0; inst_ready = 1'b1;
    tick;
    inst_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    pc_addr = 32'h0040_0008; if_ena = 1'b1;
    tick;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 11'h002) begin errors++; $display("FAIL ar_req: got req=%b addr=%h expected 1/002", mem_req, mem_addr); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({pc_step, mem_req, inst_valid, addr_err} !== 4'b0000 || mem_addr !== 11'h0 || inst_out !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL ar_clear: got ctrl=%b addr=%h out=%h pc=%h expected all 0", {pc_step, mem_req, inst_valid, addr_err}, mem_addr, inst_out, inst_pc); end
    @(negedge if_clock);
    rst = 1'b1;
    tick;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 11'h002) begin errors++; $display("FAIL ar_restart: got req=%b addr=%h expected 1/002", mem_req, mem_addr); end
    if_ena = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick;
    mem_ack = 1'b0; inst_ready = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0040_0008 || inst_out !== 32'h5555_AAAA || pc_step !== 1'b1) begin errors++; $display("FAIL ar_fetch: got v=%b pc=%h out=%h step=%b expected 1/00400008/5555aaaa/1", inst_valid, inst_pc, inst_out, pc_step); end
    tick;
    inst_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_slow_ack;
    test_flush_drain;
    test_flush_hold;
    test_addr_err;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
